// File: rtl/jtpopeye_obj_draw.sv
// Object pixel generator: fetches one ROM word per line-buffer slot and serialises it
// through two alternating lanes. Define JTPOPEYE_OBJ_MISS_EN to add miss/miss_cnt.
module jtpopeye_obj_draw #(
  parameter int unsigned ROMW    = 13,
  parameter int unsigned PXL_DLY = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic [7:0]      H,
  input  logic            HB,
  input  logic [17:0]     DJ,
  output logic [ROMW-1:0] rom_addr,
  output logic            rom_cs,
  input  logic [15:0]     rom_data,
  input  logic            rom_ok,
`ifdef JTPOPEYE_OBJ_MISS_EN
  output logic            miss,
  output logic [7:0]      miss_cnt,
`endif
  output logic [4:0]      obj_pxl
);
  localparam int unsigned CW = 4;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] READY = 2'd2;

  logic [1:0]    state, state_nx;
  logic [2:0]    ent_pal;
  logic [1:0]    ent_start;
  logic          ent_hflip;
  logic [15:0]   ent_data;
  logic [CW-1:0] cnt [2];
  logic [15:0]   shf [2];
  logic [2:0]    lpal [2];
  logic          toggle, newest, hb_l;
  logic [4:0]    dly [PXL_DLY+1];
  logic          slot_in, slot_end, fetch, capture, deadline, load, hb_rise;
  logic [1:0]    col_new, col_old;
  logic [4:0]    pix;
  logic          unused_h;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // A lane shows a pixel only once its start delay has elapsed.
  function automatic logic [1:0] lane_col(input logic [CW-1:0] c, input logic [15:0] s);
    return (c != '0 && c <= CW'(8)) ? {s[15], s[7]} : 2'b00;
  endfunction

  assign unused_h = ^H[7:2];
  assign slot_in  = (H[1:0] == 2'b01);
  assign slot_end = (H[1:0] == 2'b11);
  assign fetch    = pxl_cen && state == IDLE && slot_in && !HB && DJ[16:14] != 3'd0;
  assign deadline = pxl_cen && state == WAIT && slot_end;
  assign capture  = pxl_cen && state == WAIT && !slot_end && rom_ok;
  assign load     = pxl_cen && state == READY && slot_end;
  assign hb_rise  = HB && !hb_l;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fetch) state_nx = WAIT;
      WAIT:    if (deadline) state_nx = IDLE;
               else if (capture) state_nx = READY;
      READY:   if (load) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Entry latch and ROM request
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_cs    <= 1'b0;
      rom_addr  <= '0;
      ent_pal   <= '0;
      ent_start <= '0;
      ent_hflip <= 1'b0;
      ent_data  <= '0;
    end else begin
      if (fetch) begin
        rom_cs    <= 1'b1;
        rom_addr  <= ROMW'({DJ[17], DJ[10:4], DJ[3:1], DJ[0], 1'b0});
        ent_pal   <= DJ[16:14];
        ent_start <= DJ[13:12];
        ent_hflip <= DJ[11];
      end
      if (capture) begin
        rom_cs   <= 1'b0;
        ent_data <= rom_data;
      end
      if (deadline) rom_cs <= 1'b0;
    end
  end

  // Shift lanes; a load truncates whatever the target lane still held
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i]  <= '0;
        shf[i]  <= '0;
        lpal[i] <= '0;
      end
      toggle <= 1'b0;
      newest <= 1'b0;
      hb_l   <= 1'b0;
    end else if (pxl_cen) begin
      hb_l <= HB;
      for (int i = 0; i < 2; i++) begin
        if (load && toggle == 1'(i)) begin
          cnt[i]  <= CW'(8) + CW'(ent_start);
          shf[i]  <= ent_hflip ? {rev8(ent_data[15:8]), rev8(ent_data[7:0])} : ent_data;
          lpal[i] <= ent_pal;
        end else if (cnt[i] > CW'(8)) begin
          cnt[i] <= cnt[i] - CW'(1);
        end else if (cnt[i] != '0) begin
          shf[i] <= {shf[i][14:8], 1'b0, shf[i][6:0], 1'b0};
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
      if (load) newest <= toggle;
      if (hb_rise)   toggle <= 1'b0;
      else if (load) toggle <= ~toggle;
    end
  end

  assign col_new = lane_col(cnt[newest], shf[newest]);
  assign col_old = lane_col(cnt[~newest], shf[~newest]);

  always_comb begin
    pix = 5'd0;
    if (col_new != 2'b00)      pix = {lpal[newest], col_new};
    else if (col_old != 2'b00) pix = {lpal[~newest], col_old};
  end

  // Output register plus optional alignment stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= int'(PXL_DLY); i++) dly[i] <= '0;
    end else if (pxl_cen) begin
      dly[0] <= HB ? 5'd0 : pix;
      for (int i = 1; i <= int'(PXL_DLY); i++) dly[i] <= dly[i-1];
    end
  end

  assign obj_pxl = dly[PXL_DLY];

`ifdef JTPOPEYE_OBJ_MISS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      miss     <= 1'b0;
      miss_cnt <= '0;
    end else begin
      miss <= deadline;
      if (deadline && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_jtpopeye_obj_draw.sv
// Bench for jtpopeye_obj_draw: slot-level pixel-timeline model, directed scenarios
// with literal expectations, then randomized traffic compared every clock.
module tb_jtpopeye_obj_draw;
  localparam int unsigned ROMW = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b1, pxl_cen = 1'b0, HB = 1'b0, rom_ok = 1'b0;
  logic [7:0]      H = '0;
  logic [17:0]     DJ = '0;
  logic [15:0]     rom_data = '0;
  logic            rom_cs;
  logic [ROMW-1:0] rom_addr;
  logic [4:0]      obj_pxl;
`ifdef JTPOPEYE_OBJ_MISS_EN
  logic            miss;
  logic [7:0]      miss_cnt;
`endif

  always #5 clk = ~clk;

  jtpopeye_obj_draw #(.ROMW(ROMW), .PXL_DLY(0)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .H(H), .HB(HB), .DJ(DJ),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
`ifdef JTPOPEYE_OBJ_MISS_EN
    .miss(miss), .miss_cnt(miss_cnt),
`endif
    .obj_pxl(obj_pxl)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: each loaded object is a timeline of 8 colours starting at a known pixel tick
  int              tick = 0;
  int              pend = 0;
  logic [2:0]      p_pal;
  logic [1:0]      p_start;
  logic            p_hflip;
  logic [15:0]     p_data;
  logic            m_valid [2];
  int              m_load [2];
  int              m_start [2];
  logic [2:0]      m_pal [2];
  logic [1:0]      m_col [2][8];
  logic            m_toggle, m_newest, m_hb_prev;
  logic [4:0]      exp_pxl;
  logic            exp_cs, exp_miss;
  logic [ROMW-1:0] exp_addr;
  int              m_miss_cnt;

  // Stimulus controls
  logic [7:0]      h_cnt = 8'h00;
  logic            cs_prev = 1'b0;
  int              cs_age = 0, lat = 0, lat_a = 1, lat_b = 1;
  logic            lat_rand = 1'b0, fixed_en = 1'b0;
  logic [15:0]     fix_a = '0, fix_b = '0;
  logic [4:0]      log_pxl [256];
  logic            log_cs [256];
  logic [ROMW-1:0] log_addr [256];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [17:0] mk_dj(input logic [2:0] pal, input logic [7:0] id,
                                        input logic [1:0] st, input logic hf, input logic [3:0] lo);
    return {id[7], pal, st, hf, id[6:0], lo};
  endfunction

  function automatic logic [17:0] filler();
    logic [17:0] d;
    d = 18'($urandom);
    d[16:14] = 3'b000;
    return d;
  endfunction

  function automatic logic [15:0] rom_fn(input logic [ROMW-1:0] a);
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic hb_of(input logic [7:0] h);
    return (h >= 8'hE8) || (h < 8'h04);
  endfunction

  function automatic logic [1:0] lane_col(input int l, input int t);
    int k;
    if (!m_valid[l]) return 2'b00;
    k = t - m_load[l] - 1 - m_start[l];
    if (k < 0 || k > 7) return 2'b00;
    return m_col[l][k];
  endfunction

  task automatic model_reset();
    pend = 0;
    for (int l = 0; l < 2; l++) m_valid[l] = 1'b0;
    m_toggle = 1'b0; m_newest = 1'b0; m_hb_prev = 1'b0;
    exp_pxl = '0; exp_cs = 1'b0; exp_addr = '0; exp_miss = 1'b0; m_miss_cnt = 0;
  endtask

  task automatic model_edge(input logic r, input logic cen, input logic [7:0] h, input logic hb,
                            input logic [17:0] dj, input logic ok, input logic [15:0] data);
    logic [1:0] cn, co;
    int l;
    exp_miss = 1'b0;
    if (r) begin
      model_reset();
      return;
    end
    if (!cen) return;
    cn = lane_col(int'(m_newest), tick);
    co = lane_col(int'(!m_newest), tick);
    if (hb)              exp_pxl = 5'd0;
    else if (cn != 2'b0) exp_pxl = {m_pal[int'(m_newest)], cn};
    else if (co != 2'b0) exp_pxl = {m_pal[int'(!m_newest)], co};
    else                 exp_pxl = 5'd0;
    case (h[1:0])
      2'b01: if (pend == 0 && !hb && dj[16:14] != 3'd0) begin
        pend = 1; p_pal = dj[16:14]; p_start = dj[13:12]; p_hflip = dj[11];
        exp_cs = 1'b1;
        exp_addr = ROMW'(({dj[17], dj[10:4]} * 32) + (dj[3:0] * 2));
      end
      2'b10: if (pend == 1 && ok) begin
        pend = 2; p_data = data; exp_cs = 1'b0;
      end
      2'b11: begin
        if (pend == 1) begin
          exp_miss = 1'b1; exp_cs = 1'b0;
          if (m_miss_cnt < 255) m_miss_cnt++;
        end else if (pend == 2) begin
          l = int'(m_toggle);
          m_valid[l] = 1'b1; m_load[l] = tick; m_start[l] = int'(p_start); m_pal[l] = p_pal;
          for (int k = 0; k < 8; k++)
            m_col[l][k] = p_hflip ? {p_data[8+k], p_data[k]} : {p_data[15-k], p_data[7-k]};
          m_newest = m_toggle;
          m_toggle = !m_toggle;
        end
        pend = 0;
      end
      default: ;
    endcase
    if (hb && !m_hb_prev) m_toggle = 1'b0;
    m_hb_prev = hb;
    tick++;
  endtask

  task automatic cycle(input logic cen, input logic hb_in, input logic [17:0] dj, input logic rst_in);
    logic ok;
    logic [15:0] d;
    @(negedge clk);
    if (rom_cs) begin
      if (!cs_prev) begin
        cs_age = 0;
        if (lat_rand) lat = ($urandom_range(0, 7) < 5) ? $urandom_range(0, 1) : $urandom_range(2, 5);
        else          lat = (h_cnt < 8'h14) ? lat_a : lat_b;
      end else cs_age++;
    end else cs_age = 0;
    cs_prev = rom_cs;
    ok = rom_cs && (cs_age >= lat);
    if (!ok)          d = 16'($urandom);
    else if (fixed_en) d = (h_cnt < 8'h14) ? fix_a : fix_b;
    else              d = rom_fn(rom_addr);
    rst = rst_in; pxl_cen = cen; H = h_cnt; HB = hb_in; DJ = dj; rom_ok = ok; rom_data = d;
    @(posedge clk);
    model_edge(rst_in, cen, h_cnt, hb_in, dj, ok, d);
    #1;
    check("obj_pxl", int'(obj_pxl), int'(exp_pxl));
    check("rom_cs", int'(rom_cs), int'(exp_cs));
    if (exp_cs) check("rom_addr", int'(rom_addr), int'(exp_addr));
`ifdef JTPOPEYE_OBJ_MISS_EN
    check("miss", int'(miss), int'(exp_miss));
    check("miss_cnt", int'(miss_cnt), m_miss_cnt);
`endif
    if (cen) begin
      log_pxl[h_cnt] = obj_pxl; log_cs[h_cnt] = rom_cs; log_addr[h_cnt] = rom_addr;
      h_cnt++;
    end
  endtask

  // One short line from H=0x0C: entries at 0x11/0x15/0x21, optional reset on the H=rst_h slot
  task automatic run_line(input logic [17:0] dja, input logic [17:0] djb, input logic [17:0] djc,
                          input logic [15:0] da, input logic [15:0] db, input int la, input int lb,
                          input logic [7:0] rst_h);
    logic [17:0] d;
    fix_a = da; fix_b = db; lat_a = la; lat_b = lb; lat_rand = 1'b0; fixed_en = 1'b1;
    cycle(1'b0, 1'b0, 18'd0, 1'b1);
    cycle(1'b0, 1'b0, 18'd0, 1'b1);
    h_cnt = 8'h0C;
    for (int i = 0; i < 256; i++) begin log_pxl[i] = '0; log_cs[i] = 1'b0; log_addr[i] = '0; end
    while (h_cnt < 8'h2C) begin
      d = filler();
      if (h_cnt == 8'h11)      d = dja;
      else if (h_cnt == 8'h15) d = djb;
      else if (h_cnt == 8'h21) d = djc;
      cycle(1'b0, 1'b0, d, 1'b0);
      cycle(1'b1, 1'b0, d, h_cnt == rst_h);
    end
  endtask

  task automatic expect_run(input string name, input logic [7:0] h0, input int n, input int v);
    for (int i = 0; i < n; i++) check(name, int'(log_pxl[h0 + 8'(i)]), v);
  endtask

  initial begin
    logic [17:0] rdj;
    model_reset();

    // Plain object, no flip
    run_line(mk_dj(3'd3, 8'h05, 2'd0, 1'b0, 4'h0), filler(), filler(), 16'hF00F, 16'h0, 1, 1, 8'h00);
    check("t1_addr", int'(log_addr[8'h11]), 'h0A0);
    check("t1_pre", int'(log_pxl[8'h13]), 0);
    expect_run("t1_left", 8'h14, 4, 'h0E);
    expect_run("t1_right", 8'h18, 4, 'h0D);
    check("t1_post", int'(log_pxl[8'h1C]), 0);

    // Horizontal flip
    run_line(mk_dj(3'd3, 8'h05, 2'd0, 1'b1, 4'h0), filler(), filler(), 16'hF00F, 16'h0, 1, 1, 8'h00);
    expect_run("t2_left", 8'h14, 4, 'h0D);
    expect_run("t2_right", 8'h18, 4, 'h0E);

    // Start delay of 2 pixels
    run_line(mk_dj(3'd3, 8'h05, 2'd2, 1'b0, 4'h0), filler(), filler(), 16'hF00F, 16'h0, 1, 1, 8'h00);
    check("t3_delay", int'(log_pxl[8'h15]), 0);
    expect_run("t3_left", 8'h16, 4, 'h0E);
    expect_run("t3_right", 8'h1A, 4, 'h0D);
    check("t3_post", int'(log_pxl[8'h1E]), 0);

    // Overlap: newer lane wins where opaque
    run_line(mk_dj(3'd1, 8'h21, 2'd0, 1'b0, 4'h0), mk_dj(3'd2, 8'h42, 2'd0, 1'b0, 4'h0), filler(),
             16'hFFFF, 16'h00FF, 1, 1, 8'h00);
    expect_run("t4_old", 8'h14, 4, 'h07);
    expect_run("t4_new", 8'h18, 8, 'h09);
    check("t4_post", int'(log_pxl[8'h20]), 0);

    // Overlap: transparent newer pixels reveal the older lane
    run_line(mk_dj(3'd1, 8'h21, 2'd0, 1'b0, 4'h0), mk_dj(3'd2, 8'h42, 2'd0, 1'b0, 4'h0), filler(),
             16'hFFFF, 16'h0F0F, 1, 1, 8'h00);
    expect_run("t5_through", 8'h18, 4, 'h07);
    expect_run("t5_new", 8'h1C, 4, 'h0B);

    // Deadline miss
    run_line(mk_dj(3'd3, 8'h05, 2'd0, 1'b0, 4'h0), filler(), filler(), 16'hF00F, 16'h0, 100, 1, 8'h00);
    check("t6_cs_wait", int'(log_cs[8'h12]), 1);
    check("t6_cs_drop", int'(log_cs[8'h13]), 0);
    expect_run("t6_blank", 8'h14, 8, 0);
`ifdef JTPOPEYE_OBJ_MISS_EN
    check("t6_miss_cnt", int'(miss_cnt), 1);
`endif

    // Reset while waiting for ROM, then a normal entry
    run_line(mk_dj(3'd3, 8'h05, 2'd0, 1'b0, 4'h0), filler(), mk_dj(3'd3, 8'h05, 2'd0, 1'b0, 4'h0),
             16'hF00F, 16'hF00F, 3, 1, 8'h12);
    check("t7_cs_rst", int'(log_cs[8'h12]), 0);
    check("t7_pxl_rst", int'(log_pxl[8'h12]), 0);
    check("t7_cs_empty", int'(log_cs[8'h19]), 0);
    check("t7_cs_fetch", int'(log_cs[8'h21]), 1);
    expect_run("t7_left", 8'h24, 4, 'h0E);
    expect_run("t7_right", 8'h28, 4, 'h0D);

    // Randomized traffic over many lines
    lat_rand = 1'b1; fixed_en = 1'b0;
    cycle(1'b0, 1'b0, 18'd0, 1'b1);
    for (int n = 0; n < 30000; n++) begin
      rdj = 18'($urandom);
      if ($urandom_range(0, 3) == 0) rdj[16:14] = 3'b000;
      cycle($urandom_range(0, 2) != 0, hb_of(h_cnt), rdj, $urandom_range(0, 4999) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
